mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage pipeline, sitting between the EX/MEM register outputs of the execute stage and the write-back stage. It consumes the registered ALU result, store data and memory/write-back control bits, drives the multi-cycle data memory through a request/done handshake, and holds the upstream pipeline with `stall` while an access is outstanding. It owns the MEM/WB register, which it loads with the completed instruction or with a bubble.

## Interface
- `MAX_WAIT`, default 16. Cycles allowed in WAIT before an access is abandoned as a timeout (≥2).
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `aluOut` in 16: access address, or the ALU result passed to WB.
- `reg2Data` in 16: store data.
- `memEn`, `memWrt` in 1 each: access enable; 1 = store, 0 = load.
- `regWrt`, `halt`, `errIn` in 1 each: control bits from EX/MEM.
- `regWrtSrc`, `writeReg` in 3 each: WB source select and destination register.
- `setVal`, `nextPc` in 16 each: passed through to WB.
- `stall` out 1: freezes EX/MEM and all earlier stages.
- `dmemAddr`, `dmemDataIn` out 16 each: address and write data to data memory.
- `dmemRd`, `dmemWr` out 1 each: one-cycle request strobes.
- `dmemDataOut` in 16: read data from memory.
- `dmemDone`, `dmemErr` in 1 each: completion strobe and error flag.
- MEM/WB outputs:
  - `regWrtOut` out 1
  - `writeRegOut`, `regWrtSrcOut` out 3 each
  - `aluOutWb`, `memDataOut`, `setValOut`, `nextPcOut` out 16 each
  - `haltOut`, `errOut` out 1 each

## Operation
- FSM states: IDLE and WAIT.
- **Access:** an access is `memEn & ~aluOut[0] & ~haltOut`.
- **IDLE with an access:**
  - Assert `dmemRd` = ~`memWrt` or `dmemWr` = `memWrt`.
  - Drive `dmemAddr` = `aluOut` and `dmemDataIn` = `reg2Data`.
  - If `dmemDone` is high in the same cycle (hit), complete. Otherwise raise `stall` and go to WAIT.
- **WAIT:**
  - Strobes are low, but `dmemAddr` and `dmemDataIn` are still driven.
  - When `dmemDone` arrives, complete and return to IDLE.
- **Stall equation:** `stall` = (IDLE & access & ~dmemDone) | (WAIT & ~dmemDone & ~timeout).
  - `stall` is combinational, so it drops in the completing cycle.
- **Complete:**
  - Load MEM/WB with all pass-through fields.
  - Load `memDataOut` = `dmemDataOut` for loads and 0 for stores.
  - `errOut` = `errIn` | `dmemErr`. If `dmemErr` is set, force `regWrtOut` to 0.
- **Stall cycle:** MEM/WB loads a bubble (all fields 0).
- **Timeout:**
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - Timeout fires when the count reaches `MAX_WAIT`-1 without `dmemDone`.
  - On timeout: release `stall`, load MEM/WB with `errOut`=1, `regWrtOut`=0, `haltOut`=1, and return to IDLE.
  - `dmemDone` in the same cycle wins over timeout.
- **Unaligned address** (`memEn` & `aluOut[0]`): no request and no stall. MEM/WB loads with `errOut`=1 and `regWrtOut`=0.
- **Non-memory instruction:** passes straight into MEM/WB in one cycle.
- **Halt:**
  - Once `haltOut` has loaded as 1, it is sticky until reset.
  - All later inputs produce bubbles (with `haltOut` kept 1), and no requests are issued.
- **Reset:**
  - State goes to IDLE, the counter clears, and all MEM/WB outputs become 0.
  - `stall`, `dmemRd` and `dmemWr` are 0 during the `rst` cycle.
  - A `dmemDone` arriving after a mid-WAIT reset is ignored in IDLE; the memory shares `rst`.

## Timing
- Non-memory instruction or hit: present at cycle N, visible on MEM/WB outputs at N+1.
- Miss completing at cycle N+k: `stall` is high for cycles N..N+k-1, and data appears at N+k+1.
- Upstream holds its inputs stable while `stall`=1. The request is issued only in the first IDLE cycle, so it is never reissued.
- Worst-case stall is `MAX_WAIT` cycles.

## Structure
- Package `mem_stage_pkg` holds:
  - the state enum (IDLE=0, WAIT=1);
  - the wait-counter width, $clog2(`MAX_WAIT`);
  - the regWrtSrc encodings shared with WB.
- One sub-module, `mem_wb_latch`: a MEM/WB register bank with a synchronous clear and a bubble-load input.
- FSM, counter and strobe logic live in the top module.

## Test plan
- **ALU-only op:** `regWrt`=1, `writeReg`=3, `aluOut`=0x1234 → next cycle `regWrtOut`=1, `writeRegOut`=3, `aluOutWb`=0x1234; `stall` never asserted.
- **Load hit:** `memEn`=1, `aluOut`=0x0040, `dmemDone`=1 same cycle, `dmemDataOut`=0xBEEF → `dmemRd` pulses once, no stall, `memDataOut`=0xBEEF next cycle.
- **Store miss:** `dmemDone` arrives 3 cycles after the request → `stall` high exactly 3 cycles, `dmemWr` high 1 cycle, bubble loaded during the stall, `regWrtOut`=0.
- **Timeout:** `MAX_WAIT`=4, `dmemDone` never arrives → `stall` drops after the 4th cycle; `errOut`=1, `haltOut`=1; no further `dmemRd`/`dmemWr` even with `memEn`=1.
- **Unaligned load:** `aluOut`=0x0041 → no strobe, no stall, `errOut`=1, `regWrtOut`=0.
- **Reset mid-WAIT then late `dmemDone`:** after `rst`, all outputs are 0, state is IDLE, and the late done causes no MEM/WB load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory stage.
//   state_e     - memory-stage FSM states (IDLE=0, WAIT=1)
//   wait_cnt_w  - width of the WAIT-state counter for a given MAX_WAIT
//   SRC_*       - regWrtSrc encodings shared with write-back
//   memwb_t     - contents of the MEM/WB pipeline register
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int DEFAULT_MAX_WAIT = 16;

  // Counter only has to reach MAX_WAIT-1, so $clog2(MAX_WAIT) bits suffice.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait);
  endfunction

  localparam logic [2:0] SRC_ALU = 3'd0;
  localparam logic [2:0] SRC_MEM = 3'd1;
  localparam logic [2:0] SRC_SET = 3'd2;
  localparam logic [2:0] SRC_PC  = 3'd3;

  typedef struct packed {
    logic        regWrt;
    logic [2:0]  writeReg;
    logic [2:0]  regWrtSrc;
    logic [15:0] aluOut;
    logic [15:0] memData;
    logic [15:0] setVal;
    logic [15:0] nextPc;
    logic        halt;
    logic        err;
  } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/done bus.
//   master (memory stage): drives dmemAddr, dmemDataIn, dmemRd, dmemWr;
//                          receives dmemDataOut, dmemDone, dmemErr
//   slave  (data memory) : the reverse
interface mem_stage_if;
  logic [15:0] dmemAddr;
  logic [15:0] dmemDataIn;
  logic        dmemRd;
  logic        dmemWr;
  logic [15:0] dmemDataOut;
  logic        dmemDone;
  logic        dmemErr;

  modport master (
    output dmemAddr, dmemDataIn, dmemRd, dmemWr,
    input  dmemDataOut, dmemDone, dmemErr
  );

  modport slave (
    input  dmemAddr, dmemDataIn, dmemRd, dmemWr,
    output dmemDataOut, dmemDone, dmemErr
  );
endinterface

// File: rtl/mem_stage_mem_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register bank.
//   clk      - clock
//   clr_i    - synchronous clear of every field
//   bubble_i - load a bubble (all fields zero, halt retained)
//   d_i      - instruction to load when not a bubble
//   q_o      - registered MEM/WB contents
// The halt bit is sticky: once set it survives bubbles until cleared.
module mem_wb_latch
  import mem_stage_pkg::*;
(
  input  logic   clk,
  input  logic   clr_i,
  input  logic   bubble_i,
  input  memwb_t d_i,
  output memwb_t q_o
);

  memwb_t q_q, q_d;

  always_comb begin
    q_d      = bubble_i ? '0 : d_i;
    q_d.halt = q_q.halt | (~bubble_i & d_i.halt);
  end

  always_ff @(posedge clk) begin
    if (clr_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage between EX/MEM and write-back.
//   clk, rst          - clock, synchronous active-high reset
//   aluOut, reg2Data  - access address / ALU result, store data
//   memEn, memWrt     - access enable, 1 = store
//   regWrt, halt, errIn, regWrtSrc, writeReg, setVal, nextPc - EX/MEM control
//   stall             - holds EX/MEM and earlier stages
//   dmem              - data-memory request/done bus (master side)
//   *Out / *Wb        - MEM/WB register outputs
// A miss raises stall combinationally and parks in WAIT until dmemDone or
// until MAX_WAIT cycles have elapsed, after which the instruction retires
// as an error with halt set.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluOut,
  input  logic [15:0] reg2Data,
  input  logic        memEn,
  input  logic        memWrt,
  input  logic        regWrt,
  input  logic        halt,
  input  logic        errIn,
  input  logic [2:0]  regWrtSrc,
  input  logic [2:0]  writeReg,
  input  logic [15:0] setVal,
  input  logic [15:0] nextPc,
  output logic        stall,
  mem_stage_if.master dmem,
  output logic        regWrtOut,
  output logic [2:0]  writeRegOut,
  output logic [2:0]  regWrtSrcOut,
  output logic [15:0] aluOutWb,
  output logic [15:0] memDataOut,
  output logic [15:0] setValOut,
  output logic [15:0] nextPcOut,
  output logic        haltOut,
  output logic        errOut
);

  localparam int             CNT_W    = wait_cnt_w(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  memwb_t           wb_q, wb_d;

  logic access, unaligned, idle_acc, in_wait, timeout, mem_done, bubble;

  always_comb begin
    // Halted pipelines issue nothing further.
    access    = memEn & ~aluOut[0] & ~wb_q.halt;
    unaligned = memEn & aluOut[0];
    in_wait   = (state_q == WAIT);
    idle_acc  = (state_q == IDLE) & access;
    timeout   = in_wait & ~dmem.dmemDone & (cnt_q == CNT_LAST);
    mem_done  = (idle_acc | in_wait) & dmem.dmemDone;
    stall     = ~rst & ((idle_acc & ~dmem.dmemDone) |
                        (in_wait & ~dmem.dmemDone & ~timeout));
    bubble    = stall | wb_q.halt;
  end

  // Request strobes fire only in the IDLE cycle, so a held instruction is
  // never re-requested; address and data stay driven throughout WAIT.
  assign dmem.dmemRd     = ~rst & idle_acc & ~memWrt;
  assign dmem.dmemWr     = ~rst & idle_acc & memWrt;
  assign dmem.dmemAddr   = aluOut;
  assign dmem.dmemDataIn = reg2Data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_acc & ~dmem.dmemDone) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem.dmemDone | timeout) state_d = IDLE;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
    endcase
  end

  always_comb begin
    wb_d.regWrt    = regWrt;
    wb_d.writeReg  = writeReg;
    wb_d.regWrtSrc = regWrtSrc;
    wb_d.aluOut    = aluOut;
    wb_d.memData   = '0;
    wb_d.setVal    = setVal;
    wb_d.nextPc    = nextPc;
    wb_d.halt      = halt;
    wb_d.err       = errIn;
    if (mem_done) begin
      if (!memWrt) wb_d.memData = dmem.dmemDataOut;
      wb_d.err = errIn | dmem.dmemErr;
      if (dmem.dmemErr) wb_d.regWrt = 1'b0;
    end else if (timeout) begin
      wb_d.err    = 1'b1;
      wb_d.regWrt = 1'b0;
      wb_d.halt   = 1'b1;
    end else if (unaligned) begin
      wb_d.err    = 1'b1;
      wb_d.regWrt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB boundary
  mem_wb_latch u_mem_wb (
    .clk      (clk),
    .clr_i    (rst),
    .bubble_i (bubble),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  assign regWrtOut    = wb_q.regWrt;
  assign writeRegOut  = wb_q.writeReg;
  assign regWrtSrcOut = wb_q.regWrtSrc;
  assign aluOutWb     = wb_q.aluOut;
  assign memDataOut   = wb_q.memData;
  assign setValOut    = wb_q.setVal;
  assign nextPcOut    = wb_q.nextPc;
  assign haltOut      = wb_q.halt;
  assign errOut       = wb_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with MAX_WAIT = 4.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluOut, reg2Data, setVal, nextPc;
  logic        memEn, memWrt, regWrt, halt, errIn;
  logic [2:0]  regWrtSrc, writeReg;
  logic        stall;
  logic        regWrtOut, haltOut, errOut;
  logic [2:0]  writeRegOut, regWrtSrcOut;
  logic [15:0] aluOutWb, memDataOut, setValOut, nextPcOut;

  mem_stage_if dmem_if ();

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .aluOut       (aluOut),
    .reg2Data     (reg2Data),
    .memEn        (memEn),
    .memWrt       (memWrt),
    .regWrt       (regWrt),
    .halt         (halt),
    .errIn        (errIn),
    .regWrtSrc    (regWrtSrc),
    .writeReg     (writeReg),
    .setVal       (setVal),
    .nextPc       (nextPc),
    .stall        (stall),
    .dmem         (dmem_if.master),
    .regWrtOut    (regWrtOut),
    .writeRegOut  (writeRegOut),
    .regWrtSrcOut (regWrtSrcOut),
    .aluOutWb     (aluOutWb),
    .memDataOut   (memDataOut),
    .setValOut    (setValOut),
    .nextPcOut    (nextPcOut),
    .haltOut      (haltOut),
    .errOut       (errOut)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  memwb_t exp_q[$];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic memwb_t mk(input logic rw, input logic [2:0] wr, input logic [2:0] src,
                                input logic [15:0] alu, input logic [15:0] md,
                                input logic [15:0] sv, input logic [15:0] pc,
                                input logic h, input logic e);
    memwb_t m;
    m.regWrt = rw; m.writeReg = wr; m.regWrtSrc = src; m.aluOut = alu;
    m.memData = md; m.setVal = sv; m.nextPc = pc; m.halt = h; m.err = e;
    return m;
  endfunction

  function automatic memwb_t got_wb();
    return mk(regWrtOut, writeRegOut, regWrtSrcOut, aluOutWb, memDataOut,
              setValOut, nextPcOut, haltOut, errOut);
  endfunction

  task automatic clr_in();
    aluOut = '0; reg2Data = '0; setVal = '0; nextPc = '0;
    memEn = 0; memWrt = 0; regWrt = 0; halt = 0; errIn = 0;
    regWrtSrc = '0; writeReg = '0;
    dmem_if.dmemDone = 0; dmem_if.dmemErr = 0; dmem_if.dmemDataOut = '0;
  endtask

  // One clock: check strobes/stall mid-cycle, queue the MEM/WB expectation,
  // then pop and compare it once the edge has loaded the register.
  task automatic cyc(input string tag, input logic e_stall, input logic e_rd,
                     input logic e_wr, input memwb_t e_wb);
    memwb_t e;
    @(negedge clk);
    chk({tag, ".stall"}, stall, e_stall);
    chk({tag, ".rd"}, dmem_if.dmemRd, e_rd);
    chk({tag, ".wr"}, dmem_if.dmemWr, e_wr);
    exp_q.push_back(e_wb);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".wb"}, got_wb(), e);
  endtask

  memwb_t Z;
  memwb_t HB;

  initial begin
    Z  = '0;
    HB = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    clr_in();
    rst = 1;
    // Reset with a pending access: no stall, no strobes, MEM/WB cleared.
    memEn = 1; aluOut = 16'h0010;
    cyc("rst", 0, 0, 0, Z);
    rst = 0; clr_in();

    // ALU-only op
    regWrt = 1; writeReg = 3; aluOut = 16'h1234; setVal = 16'h5555; nextPc = 16'h0102;
    cyc("alu", 0, 0, 0, mk(1, 3, SRC_ALU, 16'h1234, 0, 16'h5555, 16'h0102, 0, 0));
    clr_in();

    // Load hit
    memEn = 1; aluOut = 16'h0040; regWrt = 1; writeReg = 5; regWrtSrc = SRC_MEM;
    dmem_if.dmemDone = 1; dmem_if.dmemDataOut = 16'hBEEF;
    #1 chk("hit.addr", dmem_if.dmemAddr, 16'h0040);
    cyc("hit", 0, 1, 0, mk(1, 5, SRC_MEM, 16'h0040, 16'hBEEF, 0, 0, 0, 0));
    clr_in();

    // Store miss, done 3 cycles after the request
    memEn = 1; memWrt = 1; aluOut = 16'h0080; reg2Data = 16'hCAFE;
    #1 chk("st.data", dmem_if.dmemDataIn, 16'hCAFE);
    cyc("st0", 1, 0, 1, Z);
    cyc("st1", 1, 0, 0, Z);
    cyc("st2", 1, 0, 0, Z);
    dmem_if.dmemDone = 1; dmem_if.dmemDataOut = 16'h1111;
    cyc("st3", 0, 0, 0, mk(0, 0, 0, 16'h0080, 0, 0, 0, 0, 0));
    clr_in();

    // Unaligned load
    memEn = 1; aluOut = 16'h0041; regWrt = 1; writeReg = 2;
    cyc("unal", 0, 0, 0, mk(0, 2, 0, 16'h0041, 0, 0, 0, 0, 1));
    clr_in();

    // Load hit with memory error
    memEn = 1; aluOut = 16'h0042; regWrt = 1; writeReg = 4;
    dmem_if.dmemDone = 1; dmem_if.dmemErr = 1; dmem_if.dmemDataOut = 16'h7777;
    cyc("merr", 0, 1, 0, mk(0, 4, 0, 16'h0042, 16'h7777, 0, 0, 0, 1));
    clr_in();

    // Reset mid-WAIT, then a late done
    memEn = 1; aluOut = 16'h0060; regWrt = 1;
    cyc("rw0", 1, 1, 0, Z);
    cyc("rw1", 1, 0, 0, Z);
    rst = 1;
    cyc("rw.rst", 0, 0, 0, Z);
    rst = 0; clr_in();
    dmem_if.dmemDone = 1; dmem_if.dmemDataOut = 16'h9999;
    cyc("late", 0, 0, 0, Z);
    clr_in();

    // Timeout: request at cycle 0, stall 4 cycles, retire as error+halt
    memEn = 1; aluOut = 16'h0020; regWrt = 1; writeReg = 6; nextPc = 16'h0200;
    cyc("to0", 1, 1, 0, Z);
    cyc("to1", 1, 0, 0, Z);
    cyc("to2", 1, 0, 0, Z);
    cyc("to3", 1, 0, 0, Z);
    cyc("to4", 0, 0, 0, mk(0, 6, 0, 16'h0020, 0, 0, 16'h0200, 1, 1));

    // Halted: accesses ignored, bubbles with halt kept
    cyc("h.ld", 0, 0, 0, HB);
    memWrt = 1;
    cyc("h.st", 0, 0, 0, HB);
    clr_in();
    regWrt = 1; writeReg = 1; aluOut = 16'h00AA;
    cyc("h.alu", 0, 0, 0, HB);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
